// File: rtl/wb_arbiter_pkg.sv
// Shared register-file geometry and writeback-arbiter sizing.
// The defines stand in for the archerdefs block when that header is absent.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef LOG2_XRF_SIZE
`define LOG2_XRF_SIZE 5
`endif
`ifndef WB_FIFO_DEPTH
`define WB_FIFO_DEPTH 2
`endif
`ifndef WB_MAX_OUTSTANDING
`define WB_MAX_OUTSTANDING 4
`endif
`ifndef WB_STARVE_LIMIT
`define WB_STARVE_LIMIT 3
`endif

package wb_arbiter_pkg;
    localparam int WB_FIFO_DEPTH      = `WB_FIFO_DEPTH;
    localparam int WB_MAX_OUTSTANDING = `WB_MAX_OUTSTANDING;
    localparam int WB_STARVE_LIMIT    = `WB_STARVE_LIMIT;
    localparam int OUTST_W            = $clog2(WB_MAX_OUTSTANDING + 1);
    localparam int STARVE_W           = $clog2(WB_STARVE_LIMIT + 1);
endpackage

// File: rtl/wb_fifo.sv
// Small rd+data FIFO that holds long-latency results awaiting a writeback slot.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN          = `XLEN,
    parameter int LOG2_XRF_SIZE = `LOG2_XRF_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [LOG2_XRF_SIZE-1:0] push_rd,
    input  logic [XLEN-1:0]          push_data,
    input  logic                     pop,
    output logic [LOG2_XRF_SIZE-1:0] head_rd,
    output logic [XLEN-1:0]          head_data,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = (WB_FIFO_DEPTH > 1) ? $clog2(WB_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [LOG2_XRF_SIZE-1:0] rd;
        logic [XLEN-1:0]          data;
    } entry_t;

    entry_t             mem_q [WB_FIFO_DEPTH];
    entry_t             mem_d [WB_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign full      = (cnt_q == CNT_W'(WB_FIFO_DEPTH));
    assign empty     = (cnt_q == '0);
    assign head_rd   = mem_q[rd_ptr_q].rd;
    assign head_data = mem_q[rd_ptr_q].data;

    // A pop while full does not open a slot until the next cycle.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = '{rd: push_rd, data: push_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)
            cnt_d = cnt_q + CNT_W'(1);
        else if (!do_push && do_pop)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle pipeline writes with buffered
// long-latency results, tracking pending destinations in a scoreboard.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN          = `XLEN,
    parameter int LOG2_XRF_SIZE = `LOG2_XRF_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iss_valid,
    input  logic [LOG2_XRF_SIZE-1:0]      iss_rd,
    output logic                          iss_ready,
    input  logic                          int_we,
    input  logic [LOG2_XRF_SIZE-1:0]      int_rd,
    input  logic [XLEN-1:0]               int_data,
    input  logic                          lat_valid,
    input  logic [LOG2_XRF_SIZE-1:0]      lat_rd,
    input  logic [XLEN-1:0]               lat_data,
    output logic                          lat_ready,
    input  logic [LOG2_XRF_SIZE-1:0]      rs1,
    input  logic [LOG2_XRF_SIZE-1:0]      rs2,
    output logic                          hazard_rs1,
    output logic                          hazard_rs2,
    output logic                          rf_we,
    output logic [LOG2_XRF_SIZE-1:0]      rf_rd,
    output logic [XLEN-1:0]               rf_wdata,
    output logic                          wb_stall,
    output logic [2**LOG2_XRF_SIZE-1:0]   pending,
    output logic                          err_waw
);
    localparam int NREG = 2**LOG2_XRF_SIZE;

    logic [NREG-1:0]          pending_q, pending_d;
    logic [OUTST_W-1:0]       outst_q, outst_d;
    logic [STARVE_W-1:0]      starve_q, starve_d;
    logic                     err_waw_q, err_waw_d;

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [LOG2_XRF_SIZE-1:0] head_rd;
    logic [XLEN-1:0]          head_data;
    logic                     int_win, iss_acc;

    wb_fifo #(.XLEN(XLEN), .LOG2_XRF_SIZE(LOG2_XRF_SIZE)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_rd   (lat_rd),
        .push_data (lat_data),
        .pop       (fifo_pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        wb_stall   = !rst && !fifo_empty && (starve_q == STARVE_W'(WB_STARVE_LIMIT));
        int_win    = !rst && int_we && (int_rd != '0) && !wb_stall;
        fifo_pop   = !rst && !fifo_empty && !int_win;
        lat_ready  = !rst && !fifo_full;
        // rd==0 results are handshaken but dropped on the floor.
        fifo_push  = lat_valid && lat_ready && (lat_rd != '0);
        iss_ready  = !rst && !pending_q[iss_rd] && (outst_q != OUTST_W'(WB_MAX_OUTSTANDING));
        iss_acc    = iss_valid && iss_ready && (iss_rd != '0);

        rf_we      = int_win || fifo_pop;
        rf_rd      = int_win ? int_rd : head_rd;
        rf_wdata   = int_win ? int_data : head_data;

        hazard_rs1 = pending_q[rs1] && (rs1 != '0);
        hazard_rs2 = pending_q[rs2] && (rs2 != '0);

        pending_d  = pending_q;
        if (fifo_pop)
            pending_d[head_rd] = 1'b0;
        if (iss_acc)
            pending_d[iss_rd] = 1'b1;
        pending_d[0] = 1'b0;

        outst_d = outst_q;
        if (iss_acc && !(fifo_pop && outst_q != '0))
            outst_d = outst_q + OUTST_W'(1);
        else if (!iss_acc && fifo_pop && outst_q != '0)
            outst_d = outst_q - OUTST_W'(1);

        if (fifo_empty || fifo_pop)
            starve_d = '0;
        else
            starve_d = starve_q + STARVE_W'(1);

        err_waw_d = err_waw_q || (int_win && pending_q[int_rd]);
    end

    assign pending = pending_q;
    assign err_waw = err_waw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            outst_q   <= '0;
            starve_q  <= '0;
            err_waw_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            outst_q   <= outst_d;
            starve_q  <= starve_d;
            err_waw_q <= err_waw_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: hand-computed expectations per cycle.
module tb_wb_arbiter;
    localparam int XL = 32;
    localparam int LG = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid;
    logic [LG-1:0] iss_rd;
    logic          iss_ready;
    logic          int_we;
    logic [LG-1:0] int_rd;
    logic [XL-1:0] int_data;
    logic          lat_valid;
    logic [LG-1:0] lat_rd;
    logic [XL-1:0] lat_data;
    logic          lat_ready;
    logic [LG-1:0] rs1, rs2;
    logic          hazard_rs1, hazard_rs2;
    logic          rf_we;
    logic [LG-1:0] rf_rd;
    logic [XL-1:0] rf_wdata;
    logic          wb_stall;
    logic [31:0]   pending;
    logic          err_waw;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XL), .LOG2_XRF_SIZE(LG)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .int_we(int_we), .int_rd(int_rd), .int_data(int_data),
        .lat_valid(lat_valid), .lat_rd(lat_rd), .lat_data(lat_data), .lat_ready(lat_ready),
        .rs1(rs1), .rs2(rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .wb_stall(wb_stall), .pending(pending), .err_waw(err_waw)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs then change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_rd = 0;
        int_we = 0; int_rd = 0; int_data = 0;
        lat_valid = 0; lat_rd = 0; lat_data = 0;
        rs1 = 0; rs2 = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        cyc(); cyc();
        iss_valid = 1; iss_rd = 6; lat_valid = 1; lat_rd = 6;
        settle();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_lat_ready", lat_ready, 0);
        chk("rst_iss_ready", iss_ready, 0);
        chk("rst_wb_stall", wb_stall, 0);
        chk("rst_pending", pending, 0);
        chk("rst_err_waw", err_waw, 0);
        idle();
        cyc();
        rst = 0;
        settle();
        chk("post_rst_lat_ready", lat_ready, 1);
        chk("post_rst_iss_ready", iss_ready, 1);

        // rd=0 issue never marks pending
        iss_valid = 1; iss_rd = 0;
        cyc(); idle(); settle();
        chk("pend0_held_zero", pending, 0);

        // Basic issue -> result -> writeback
        iss_valid = 1; iss_rd = 5;
        settle();
        chk("iss5_ready", iss_ready, 1);
        cyc(); idle(); settle();
        chk("pend5_set", pending, 32'h0000_0020);
        lat_valid = 1; lat_rd = 5; lat_data = 32'hDEADBEEF;
        settle();
        chk("lat5_ready", lat_ready, 1);
        chk("lat5_no_we_yet", rf_we, 0);
        cyc(); idle(); settle();
        chk("wb5_we", rf_we, 1);
        chk("wb5_rd", rf_rd, 5);
        chk("wb5_data", rf_wdata, 32'hDEADBEEF);
        chk("wb5_pend_still", pending, 32'h0000_0020);
        cyc(); settle();
        chk("wb5_pend_clear", pending, 0);
        chk("wb5_we_after", rf_we, 0);

        // Starvation under continuous int writes
        iss_valid = 1; iss_rd = 7;
        cyc(); idle();
        int_we = 1; int_rd = 3; int_data = 32'h33;
        lat_valid = 1; lat_rd = 7; lat_data = 32'h77;
        cyc(); lat_valid = 0; lat_rd = 0; lat_data = 0; settle();
        chk("starve_w1_rd", rf_rd, 3);
        chk("starve_w1_stall", wb_stall, 0);
        cyc(); settle();
        chk("starve_w2_rd", rf_rd, 3);
        cyc(); settle();
        chk("starve_w3_rd", rf_rd, 3);
        chk("starve_w3_stall", wb_stall, 0);
        cyc(); settle();
        chk("starve_w4_stall", wb_stall, 1);
        chk("starve_w4_we", rf_we, 1);
        chk("starve_w4_rd", rf_rd, 7);
        chk("starve_w4_data", rf_wdata, 32'h77);
        cyc(); settle();
        chk("starve_after_stall", wb_stall, 0);
        chk("starve_after_rd", rf_rd, 3);
        chk("starve_after_pend", pending, 0);
        idle();

        // Duplicate rd and outstanding limit
        iss_valid = 1; iss_rd = 9; settle();
        chk("iss9_first", iss_ready, 1);
        cyc(); settle();
        chk("iss9_second", iss_ready, 0);
        iss_rd = 10; cyc();
        iss_rd = 11; cyc();
        iss_rd = 12; cyc();
        iss_rd = 13; settle();
        chk("iss_fifth_blocked", iss_ready, 0);
        chk("pend_four", pending, 32'h0000_1E00);
        lat_valid = 1; lat_rd = 9; lat_data = 32'h99;
        cyc(); lat_valid = 0; lat_rd = 0; settle();
        chk("pop9_we", rf_we, 1);
        chk("pop9_rd", rf_rd, 9);
        chk("iss_blocked_during_pop", iss_ready, 0);
        cyc(); settle();
        chk("iss_fifth_after_pop", iss_ready, 1);
        cyc(); idle(); settle();
        chk("pend_after_13", pending, 32'h0000_3C00);

        // Fill FIFO while int busy
        int_we = 1; int_rd = 3; int_data = 32'h33;
        lat_valid = 1; lat_rd = 10; lat_data = 32'hA0;
        cyc(); lat_rd = 11; lat_data = 32'hB0; settle();
        chk("fill_one_ready", lat_ready, 1);
        cyc(); lat_valid = 0; lat_rd = 0; lat_data = 0; settle();
        chk("fill_full_ready", lat_ready, 0);
        chk("fill_full_rd", rf_rd, 3);
        cyc(); int_we = 0; int_rd = 0; int_data = 0;
        lat_valid = 1; lat_rd = 0; lat_data = 32'hFF; settle();
        chk("full_pop_rd", rf_rd, 10);
        chk("full_pop_ready", lat_ready, 0);
        cyc(); settle();
        chk("pop11_rd", rf_rd, 11);
        chk("rd0_ready", lat_ready, 1);
        cyc(); lat_valid = 0; lat_data = 0; settle();
        chk("rd0_no_write", rf_we, 0);
        chk("pend_12_13", pending, 32'h0000_3000);

        // Hazards and WAW
        iss_valid = 1; iss_rd = 4;
        cyc(); idle();
        rs1 = 4; rs2 = 0; settle();
        chk("haz_rs1", hazard_rs1, 1);
        chk("haz_rs2", hazard_rs2, 0);
        rs2 = 12; settle();
        chk("haz_rs2_12", hazard_rs2, 1);
        int_we = 1; int_rd = 4; int_data = 32'h44; settle();
        chk("waw_write_done", rf_we, 1);
        chk("waw_before", err_waw, 0);
        cyc(); idle(); settle();
        chk("waw_set", err_waw, 1);
        cyc(); cyc(); settle();
        chk("waw_sticky", err_waw, 1);

        // Reset with full FIFO
        int_we = 1; int_rd = 3; int_data = 32'h33;
        lat_valid = 1; lat_rd = 12; lat_data = 32'hC0;
        cyc(); lat_rd = 13; lat_data = 32'hD0;
        cyc(); lat_valid = 0; lat_rd = 0; lat_data = 0; settle();
        chk("rst_full_ready", lat_ready, 0);
        rst = 1; int_we = 0; int_rd = 0; settle();
        chk("rst_mid_we", rf_we, 0);
        chk("rst_mid_lat_ready", lat_ready, 0);
        cyc(); settle();
        chk("rst_mid_waw_clr", err_waw, 0);
        rst = 0; settle();
        chk("rel_we", rf_we, 0);
        chk("rel_pend", pending, 0);
        chk("rel_lat_ready", lat_ready, 1);
        chk("rel_iss_ready", iss_ready, 1);
        cyc(); settle();
        chk("rel_we_next", rf_we, 0);
        cyc(); settle();
        chk("rel_we_next2", rf_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN, datapath width.
REQ-002 SHALL have parameter LOG2_XRF_SIZE, default `LOG2_XRF_SIZE, register index width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have ports iss_valid in 1 / iss_rd in LOG2_XRF_SIZE / iss_ready out 1  long-latency op issue; marks rd pending.
REQ-006 SHALL have ports int_we in 1 / int_rd in LOG2_XRF_SIZE / int_data in XLEN  single-cycle pipeline writeback; no backpressure.
REQ-007 SHALL have ports lat_valid in 1 / lat_rd in LOG2_XRF_SIZE / lat_data in XLEN / lat_ready out 1  long-latency result handshake.
REQ-008 SHALL have ports rs1, rs2 in LOG2_XRF_SIZE / hazard_rs1, hazard_rs2 out 1  source-operand pending check.
REQ-009 SHALL have ports rf_we out 1 / rf_rd out LOG2_XRF_SIZE / rf_wdata out XLEN  to register-file RegWrite/rd/datain.
REQ-010 SHALL have ports wb_stall out 1 (pipeline must hold writeback), pending out 2**LOG2_XRF_SIZE (scoreboard), err_waw out 1 (sticky).

Function
REQ-011 SHALL buffer accepted lat results in a 2-entry FIFO; lat_ready = FIFO not full; transfer on lat_valid && lat_ready.
REQ-012 SHALL accept-and-discard lat results with lat_rd==0 (not enqueued, no rf write).
REQ-013 SHALL drive rf port combinationally: int wins when int_we && int_rd!=0 && !wb_stall; else FIFO head pops when non-empty; else rf_we=0.
REQ-014 SHALL count consecutive cycles FIFO non-empty but not popped (starve_cnt, 0..3); reset to 0 on pop or when empty.
REQ-015 SHALL assert wb_stall combinationally when starve_cnt==3 && FIFO non-empty; that cycle FIFO head pops regardless of int_we, and int write is not performed.
REQ-016 SHALL set pending[iss_rd] on issue accept (iss_valid && iss_ready && iss_rd!=0); clear pending[rf_rd] on the FIFO-pop cycle edge.
REQ-017 SHALL deassert iss_ready when pending[iss_rd]==1 (even if clearing this cycle) or outstanding count==4.
REQ-018 SHALL track outstanding count 0..4: +1 on accepted issue with rd!=0, -1 on FIFO pop; simultaneous -> unchanged.
REQ-019 SHALL drive hazard_rsN = pending[rsN] && rsN!=0, combinational, without forwarding of a same-cycle pop.
REQ-020 SHALL set err_waw when an int write targets a pending rd; write still performed.
REQ-021 SHALL hold pending[0]=0 at all times.
REQ-022 SHALL allow enqueue and pop in the same cycle when full (pop frees slot only next cycle; lat_ready stays low).

Reset
REQ-023 SHALL, while rst high: FIFO empty, pending=0, outstanding=0, starve_cnt=0, err_waw=0.
REQ-024 SHALL force rf_we=0, lat_ready=0, iss_ready=0, wb_stall=0 while rst high.
REQ-025 SHALL discard in-flight FIFO contents and pending bits on reset mid-operation; no write issued for them afterwards.

Structure
REQ-026 SHALL take XLEN and LOG2_XRF_SIZE from the shared archerdefs defines; add WB_FIFO_DEPTH (2), WB_MAX_OUTSTANDING (4), WB_STARVE_LIMIT (3) there.
REQ-027 SHALL instantiate one sub-module wb_fifo (2-entry rd+data FIFO with full/empty); scoreboard and mux stay in wb_arbiter.

Verification
REQ-028 Issue rd=5, then lat result rd=5 data 0xDEADBEEF with int idle -> rf_we=1, rf_rd=5 same cycle as head; pending[5]=0 next cycle.
REQ-029 Issue rd=7, int_we every cycle to rd=3, lat result rd=7 -> wb_stall on 4th waiting cycle, FIFO writes x7, int write that cycle suppressed.
REQ-030 Issue rd=9 twice back-to-back -> second iss_ready=0; four distinct issues then fifth -> iss_ready=0 until a pop.
REQ-031 Fill FIFO (2 results, int busy) -> lat_ready=0; lat result rd=0 when space -> accepted, no rf write.
REQ-032 Pending rd=4, rs1=4, rs2=0 -> hazard_rs1=1, hazard_rs2=0; int_we rd=4 -> err_waw=1 sticky until rst.
REQ-033 Assert rst with FIFO holding 2 entries -> after release: no rf_we, pending=0, lat_ready=1.
